fifo_access_sched: RTL and testbench
====================================

Name: fifo_access_sched

Overview:
- Access scheduler in front of the shared 16-entry, 8-bit FIFO. Several producers compete for the FIFO write port, and one consumer requests reads.
- Producers are granted round-robin. A write-burst limit stops writes from starving the consumer, because the FIFO drops a read in any cycle that also carries an accepted write.
- The block drives the FIFO wr/rd/din pins and returns read data to the consumer with a valid strobe.

Parameters:
- NUM_REQ, 4, number of producer ports (2..8).
- DATA_W, 8, data width; must match the FIFO width.
- MAX_WR_BURST, 4, maximum consecutive write slots while a read is pending (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer write request; level; held until granted.
- din  in  NUM_REQ*DATA_W  producer data; producer i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, combinational; gnt[i]=1 means producer i's data is written at this clock edge.
- rd_req  in  1  consumer read request; level; one entry per cycle while held and issued.
- rd_valid  out  1  registered; high for one cycle per completed read.
- rd_data  out  DATA_W  valid when rd_valid=1; equals fifo_dout.
- fifo_wr  out  1  to FIFO wr.
- fifo_rd  out  1  to FIFO rd.
- fifo_din  out  DATA_W  to FIFO data_in.
- fifo_full  in  1  FIFO full flag, current cycle.
- fifo_empty  in  1  FIFO empty flag, current cycle.
- fifo_dout  in  DATA_W  FIFO registered read data.

Behaviour:
- State:
  - rr_ptr: index of the highest-priority producer.
  - burst_cnt: saturating count of consecutive write slots taken while rd_req=1.
  - rd_valid register.
- Slot decision (combinational, evaluated every cycle):
  - wr_ok = |req && !fifo_full.
  - rd_ok = rd_req && !fifo_empty.
  - rd_turn = rd_ok && (burst_cnt >= MAX_WR_BURST || !wr_ok).
  - If rd_turn: READ slot. fifo_rd=1, fifo_wr=0, gnt=0.
  - Else if wr_ok: WRITE slot. The winner is the first requesting index found scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. fifo_wr=1, gnt[winner]=1, fifo_din=din[winner], fifo_rd=0.
  - Else: IDLE. All outputs to the FIFO are 0; fifo_din=0.
- fifo_wr and fifo_rd are never high in the same cycle.
- Sequential updates (when not in reset):
  - WRITE slot: rr_ptr <= (winner+1) mod NUM_REQ. burst_cnt <= min(burst_cnt+1, MAX_WR_BURST) if rd_req=1, else 0.
  - READ slot: burst_cnt <= 0. rr_ptr unchanged.
  - IDLE: burst_cnt <= 0 if rd_req=0, otherwise held. rr_ptr unchanged.
  - rd_valid <= fifo_rd.
- Read latency:
  - fifo_rd in cycle N gives rd_valid=1 in cycle N+1.
  - rd_data = fifo_dout in that cycle, which the FIFO loaded at the N edge.
- Boundaries:
  - full with rd_ok: read slot regardless of burst_cnt.
  - empty: no read is issued even if burst_cnt is saturated; writes proceed.
  - Single requester: granted every eligible cycle.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Ungranted producers hold req and din.
- Reset:
  - While rst=1: gnt=0, fifo_wr=0, fifo_rd=0, fifo_din=0.
  - At the edge: rr_ptr=0, burst_cnt=0, rd_valid=0.
  - Reset asserted mid-burst discards the pending read-return slot; rd_valid=0 in the following cycle.
- Widths:
  - rr_ptr: $clog2(NUM_REQ) bits.
  - burst_cnt: $clog2(MAX_WR_BURST+1) bits.

Decomposition:
- Package fifo_sched_pkg holds the default constants (NUM_REQ, DATA_W, MAX_WR_BURST) and the typedef slot_e {SLOT_IDLE, SLOT_WRITE, SLOT_READ}.
- One sub-module, rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs req, ptr; outputs one-hot gnt, winner index, any.
  - Purely combinational; rr_ptr lives in the parent.

Test Plan:
- Reset, then req=4'b1111, rd_req=0, FIFO empty → grants 0,1,2,3,0,1,... on consecutive cycles; fifo_din tracks the granted din; full after 16 writes, then gnt=0 and fifo_wr=0.
- req=4'b0101 held, rr_ptr=0 → grants alternate 0,2,0,2; producer 2 is never skipped.
- FIFO holding 3 entries, req=4'b1111 held, rd_req=1 held, MAX_WR_BURST=4 → pattern W,W,W,W,R repeats; rd_valid one cycle after each R, with rd_data in FIFO order.
- FIFO full (16 entries), req=4'b0001, rd_req=1 → immediate read slot; the next cycle writes since the FIFO is no longer full; rd_valid=1 with the oldest data.
- FIFO empty, rd_req=1, req=0 → fifo_rd stays 0 and rd_valid stays 0; after one write of 8'hA5, the next cycle reads and then rd_valid=1 with rd_data=8'hA5.
- rst asserted in the cycle a read issues → the next cycle has rd_valid=0, rr_ptr=0, burst_cnt=0, gnt=0; after release, grant starts at producer 0.

Source files
------------

// File: rtl/fifo_access_sched_pkg.sv
// Shared constants and slot encoding for the FIFO access scheduler.
// Defaults: 4 producers, 8-bit data, and a 4-slot write burst limit while a read is pending.
package fifo_sched_pkg;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 8;
  localparam int MAX_WR_BURST = 4;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_WRITE = 2'd1,
    SLOT_READ  = 2'd2
  } slot_e;

endpackage

// File: rtl/fifo_access_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NUM_REQ.
// Zero latency; the priority pointer is owned and advanced by the parent.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   winner,
  output logic               any
);

  assign any = |req;

  // Scan from the far end back toward ptr so the last hit is the nearest requester.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) winner = PTR_W'(idx);
    end
  end

  always_comb begin
    gnt = '0;
    if (any) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/fifo_access_sched.sv
// Shares one FIFO between round-robin producers and a single reader; writes are capped at
// MAX_WR_BURST slots while a read waits. Grants are same-cycle; read data returns one cycle after fifo_rd.
module fifo_access_sched
  import fifo_sched_pkg::*;
#(
  parameter int  NUM_REQ      = fifo_sched_pkg::NUM_REQ,
  parameter int  DATA_W       = fifo_sched_pkg::DATA_W,
  parameter int  MAX_WR_BURST = fifo_sched_pkg::MAX_WR_BURST,
  localparam int PTR_W        = $clog2(NUM_REQ),
  localparam int BURST_W      = $clog2(MAX_WR_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      rd_req,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      fifo_wr,
  output logic                      fifo_rd,
  output logic [DATA_W-1:0]         fifo_din,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic [DATA_W-1:0]         fifo_dout
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_WR_BURST);
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   rr_ptr;
  logic [BURST_W-1:0] burst_cnt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_winner;
  logic               arb_any;
  logic               wr_ok;
  logic               rd_ok;
  logic               rd_turn;
  slot_e              slot;
  logic [PTR_W-1:0]   next_ptr;
  logic [BURST_W-1:0] burst_inc;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .winner (arb_winner),
    .any    (arb_any)
  );

  assign wr_ok   = arb_any && !fifo_full;
  assign rd_ok   = rd_req && !fifo_empty;
  assign rd_turn = rd_ok && ((burst_cnt >= BURST_MAX) || !wr_ok);

  // Reset forces an idle slot so nothing reaches the FIFO pins while rst is high.
  always_comb begin
    slot = SLOT_IDLE;
    if (!rst) begin
      if (rd_turn)    slot = SLOT_READ;
      else if (wr_ok) slot = SLOT_WRITE;
    end
  end

  assign fifo_rd  = (slot == SLOT_READ);
  assign fifo_wr  = (slot == SLOT_WRITE);
  assign gnt      = fifo_wr ? arb_gnt : '0;
  assign fifo_din = fifo_wr ? din[int'(arb_winner)*DATA_W +: DATA_W] : '0;
  assign rd_data  = fifo_dout;

  assign next_ptr  = (arb_winner == PTR_LAST) ? '0 : arb_winner + 1'b1;
  assign burst_inc = (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= fifo_rd;
      case (slot)
        SLOT_WRITE: begin
          rr_ptr    <= next_ptr;
          burst_cnt <= rd_req ? burst_inc : '0;
        end
        SLOT_READ: burst_cnt <= '0;
        default: begin
          if (!rd_req) burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_access_sched.sv
// Directed bench for fifo_access_sched with a behavioural 16x8 FIFO attached to its FIFO pins.
module tb_fifo_access_sched;

  localparam int NR = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*DW-1:0] din = '0;
  logic [NR-1:0] gnt;
  logic          rd_req = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [DW-1:0] fifo_din;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;

  logic          fifo_clr = 1'b1;
  logic [DW-1:0] mem [16];
  logic [3:0]    wp;
  logic [3:0]    rp;
  logic [4:0]    cnt;
  logic [DW-1:0] dval [NR];

  int checks   = 0;
  int failures = 0;

  logic [NR-1:0] exp_g [11];
  logic [DW-1:0] exp_d [11];
  logic          exp_r [11];
  logic          exp_v [11];
  logic [DW-1:0] exp_q [11];

  always #5 clk = ~clk;

  fifo_access_sched #(.NUM_REQ(NR), .DATA_W(DW), .MAX_WR_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_wr    (fifo_wr),
    .fifo_rd    (fifo_rd),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout)
  );

  assign fifo_full  = (cnt == 5'd16);
  assign fifo_empty = (cnt == 5'd0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (fifo_wr && !fifo_full) begin
        mem[wp] <= fifo_din;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd && !fifo_empty) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 4'd1;
      end
      cnt <= cnt + {4'd0, fifo_wr && !fifo_full} - {4'd0, fifo_rd && !fifo_empty};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_din();
    for (int i = 0; i < NR; i++) din[i*DW +: DW] = dval[i];
  endtask

  // Producers advance their data only after being granted; others hold req and din.
  task automatic next_cycle();
    logic [NR-1:0] g;
    g = gnt;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (g[i]) dval[i] = dval[i] + 8'd1;
    drive_din();
  endtask

  task automatic reinit();
    rst = 1'b1; fifo_clr = 1'b1; req = '0; rd_req = 1'b0;
    #1;
    next_cycle();
    for (int i = 0; i < NR; i++) dval[i] = 8'(i * 16);
    drive_din();
    rst = 1'b0; fifo_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) dval[i] = 8'(i * 16);
    drive_din();
    rst = 1'b1; fifo_clr = 1'b1; req = 4'b1111; rd_req = 1'b1;
    @(negedge clk); #1;
    chk("rst_gnt",  32'(gnt),      32'(0));
    chk("rst_wr",   32'(fifo_wr),  32'(0));
    chk("rst_rd",   32'(fifo_rd),  32'(0));
    chk("rst_din",  32'(fifo_din), 32'(0));
    next_cycle();
    rst = 1'b0; fifo_clr = 1'b0; req = 4'b1111; rd_req = 1'b0; #1;
    chk("rst_rv",    32'(rd_valid),      32'(0));
    chk("rst_ptr",   32'(dut.rr_ptr),    32'(0));
    chk("rst_burst", 32'(dut.burst_cnt), 32'(0));

    // All four producers fill an empty FIFO in strict rotation.
    for (int j = 0; j < 16; j++) begin
      chk("fill_gnt", 32'(gnt),      32'(1 << (j % 4)));
      chk("fill_din", 32'(fifo_din), 32'((j % 4) * 16 + j / 4));
      chk("fill_wr",  32'(fifo_wr),  32'(1));
      next_cycle(); #1;
    end
    chk("full_gnt", 32'(gnt),     32'(0));
    chk("full_wr",  32'(fifo_wr), 32'(0));
    chk("full_rd",  32'(fifo_rd), 32'(0));

    // Full FIFO with a read pending: read wins immediately, then alternates with writes.
    next_cycle();
    rd_req = 1'b1; req = 4'b0001; #1;
    chk("fullrd_rd",  32'(fifo_rd), 32'(1));
    chk("fullrd_gnt", 32'(gnt),     32'(0));
    next_cycle(); #1;
    chk("fullrd_rv",    32'(rd_valid), 32'(1));
    chk("fullrd_data",  32'(rd_data),  32'(8'h00));
    chk("fullrd_wgnt",  32'(gnt),      32'(4'b0001));
    chk("fullrd_wdin",  32'(fifo_din), 32'(8'h04));
    next_cycle(); #1;
    chk("fullrd2_rd",  32'(fifo_rd), 32'(1));
    chk("fullrd2_gnt", 32'(gnt),     32'(0));
    next_cycle(); #1;
    chk("fullrd2_rv",   32'(rd_valid), 32'(1));
    chk("fullrd2_data", 32'(rd_data),  32'(8'h10));

    // Two sparse requesters alternate; producer 2 is never skipped.
    reinit();
    req = 4'b0101; #1;
    chk("alt0_gnt", 32'(gnt), 32'(4'b0001));
    chk("alt0_din", 32'(fifo_din), 32'(8'h00));
    next_cycle(); #1;
    chk("alt1_gnt", 32'(gnt), 32'(4'b0100));
    chk("alt1_din", 32'(fifo_din), 32'(8'h20));
    next_cycle(); #1;
    chk("alt2_gnt", 32'(gnt), 32'(4'b0001));
    chk("alt2_din", 32'(fifo_din), 32'(8'h01));
    next_cycle();

    // FIFO holds 00,20,01; rr_ptr=1. Burst limit yields W,W,W,W,R.
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000,
              4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0010};
    exp_d = '{8'h10, 8'h21, 8'h30, 8'h02, 8'h00,
              8'h11, 8'h22, 8'h31, 8'h03, 8'h00, 8'h12};
    exp_r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
    req = 4'b1111; rd_req = 1'b1; #1;
    for (int k = 0; k < 11; k++) begin
      chk("burst_gnt", 32'(gnt),      32'(exp_g[k]));
      chk("burst_rd",  32'(fifo_rd),  32'(exp_r[k]));
      chk("burst_rv",  32'(rd_valid), 32'(exp_v[k]));
      if (exp_g[k] != '0) chk("burst_din",  32'(fifo_din), 32'(exp_d[k]));
      if (exp_v[k])       chk("burst_data", 32'(rd_data),  32'(exp_q[k]));
      next_cycle(); #1;
    end

    // Empty FIFO: a pending read waits for data, then returns it.
    reinit();
    req = 4'b0000; rd_req = 1'b1; #1;
    chk("empty_rd",  32'(fifo_rd), 32'(0));
    chk("empty_gnt", 32'(gnt),     32'(0));
    next_cycle(); #1;
    chk("empty_rv",  32'(rd_valid), 32'(0));
    chk("empty_rd2", 32'(fifo_rd),  32'(0));
    dval[0] = 8'hA5; drive_din(); req = 4'b0001; #1;
    chk("a5_gnt", 32'(gnt),      32'(4'b0001));
    chk("a5_din", 32'(fifo_din), 32'(8'hA5));
    chk("a5_rd",  32'(fifo_rd),  32'(0));
    next_cycle();
    req = 4'b0000; #1;
    chk("a5_rdslot", 32'(fifo_rd),  32'(1));
    chk("a5_rv0",    32'(rd_valid), 32'(0));
    next_cycle(); #1;
    chk("a5_rv",   32'(rd_valid), 32'(1));
    chk("a5_data", 32'(rd_data),  32'(8'hA5));
    chk("a5_rd2",  32'(fifo_rd),  32'(0));

    // Reset lands in the cycle a read would issue.
    dval[2] = 8'h5A; drive_din(); req = 4'b0100; rd_req = 1'b1; #1;
    chk("pre_gnt", 32'(gnt), 32'(4'b0100));
    next_cycle();
    rst = 1'b1; req = 4'b0000; rd_req = 1'b1; #1;
    chk("pre_ptr",   32'(dut.rr_ptr),    32'(3));
    chk("pre_burst", 32'(dut.burst_cnt), 32'(1));
    chk("mid_rd",    32'(fifo_rd),       32'(0));
    chk("mid_gnt",   32'(gnt),           32'(0));
    chk("mid_wr",    32'(fifo_wr),       32'(0));
    next_cycle();
    rst = 1'b0; req = 4'b1111; rd_req = 1'b0; #1;
    chk("post_rv",    32'(rd_valid),      32'(0));
    chk("post_ptr",   32'(dut.rr_ptr),    32'(0));
    chk("post_burst", 32'(dut.burst_cnt), 32'(0));
    chk("post_gnt",   32'(gnt),           32'(4'b0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
